// File: rtl/spi_flash_cmd_seq.sv
// SPI flash command sequencer: frames RDID/RDSR/READ/WREN around a byte-wide shift engine.
// Optional per-exchange timeout abort is compiled in with `define SPI_SEQ_TIMEOUT_EN.
module spi_flash_cmd_seq #(
  parameter int unsigned CS_SETUP_CYC = 2,
  parameter int unsigned CS_HOLD_CYC  = 2,
  parameter int unsigned CS_DESEL_CYC = 4,
  parameter int unsigned TIMEOUT_CYC  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_last,
  output logic        busy,
  output logic        err,
  output logic        cs_n,
  output logic        xfer_start,
  output logic [7:0]  xfer_tx,
  input  logic        xfer_done,
  input  logic [7:0]  xfer_rx
);
  localparam int unsigned MAX_A = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int unsigned MAX_B = (MAX_A > CS_DESEL_CYC) ? MAX_A : CS_DESEL_CYC;
  localparam int unsigned MAX_C = (MAX_B > 256) ? MAX_B : 256;
  localparam int unsigned CNT_W = $clog2(MAX_C + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] OP_RDID = 2'd0;
  localparam logic [1:0] OP_RDSR = 2'd1;
  localparam logic [1:0] OP_READ = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_OPCODE, S_ADDR, S_DATA, S_HOLD, S_DESEL
  } state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [23:0] addr;
    logic [7:0]  len;
  } cmd_t;

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_last_q, rsp_last_d;
  logic             xchg, start, fin, tmo_hit;
  logic [7:0]       tx_byte;

  // pend_q marks an exchange in flight; a new start only issues once it clears
  assign xchg  = state_q inside {S_OPCODE, S_ADDR, S_DATA};
  assign start = xchg && !pend_q;
  assign fin   = xchg && pend_q && xfer_done;

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // tmo_q equals the number of cycles elapsed since the outstanding xfer_start
  assign tmo_d   = start ? TMO_W'(1) : (pend_q ? tmo_q + 1'b1 : '0);
  assign tmo_hit = xchg && pend_q && !xfer_done && (tmo_q >= TMO_W'(TIMEOUT_CYC - 1));
  assign err_d   = tmo_hit;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`else
  logic [TMO_W-1:0] unused_tmo;
  assign unused_tmo = '0;
  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = 1'b0;
    if (start) pend_d = 1'b1;
    if (fin)   pend_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (cmd_valid) begin
        state_d = S_SETUP;
        cmd_d   = '{op: cmd_op, addr: cmd_addr, len: cmd_len};
        cnt_d   = CNT_W'(CS_SETUP_CYC - 1);
      end
      S_SETUP: if (cnt_q == '0) state_d = S_OPCODE;
               else cnt_d = cnt_q - 1'b1;
      S_OPCODE: if (fin) begin
        case (cmd_q.op)
          OP_READ: begin state_d = S_ADDR; cnt_d = CNT_W'(2); end
          OP_RDID: begin state_d = S_DATA; cnt_d = CNT_W'(2); end
          OP_RDSR: begin state_d = S_DATA; cnt_d = '0; end
          default: begin state_d = S_HOLD; cnt_d = CNT_W'(CS_HOLD_CYC - 1); end
        endcase
      end
      S_ADDR: if (fin) begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = CNT_W'(cmd_q.len);
        end else cnt_d = cnt_q - 1'b1;
      end
      S_DATA: if (fin) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = xfer_rx;
        rsp_last_d  = (cnt_q == '0);
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(CS_HOLD_CYC - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      S_HOLD: if (cnt_q == '0) begin
        state_d = S_DESEL;
        cnt_d   = CNT_W'(CS_DESEL_CYC - 1);
      end else cnt_d = cnt_q - 1'b1;
      S_DESEL: if (cnt_q == '0) state_d = S_IDLE;
               else cnt_d = cnt_q - 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_d = S_HOLD;
      cnt_d   = CNT_W'(CS_HOLD_CYC - 1);
      pend_d  = 1'b0;
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    unique case (state_q)
      S_OPCODE: case (cmd_q.op)
        OP_RDID: tx_byte = 8'h9F;
        OP_RDSR: tx_byte = 8'h05;
        OP_READ: tx_byte = 8'h03;
        default: tx_byte = 8'h06;
      endcase
      // address bytes go MSB first while cnt_q walks 2,1,0
      S_ADDR: tx_byte = (cnt_q == CNT_W'(2)) ? cmd_q.addr[23:16] :
                        (cnt_q == CNT_W'(1)) ? cmd_q.addr[15:8] : cmd_q.addr[7:0];
      default: tx_byte = 8'h00;
    endcase
    cmd_ready  = (state_q == S_IDLE) && !reset;
    busy       = (state_q != S_IDLE);
    cs_n       = state_q inside {S_IDLE, S_DESEL};
    xfer_start = start;
    xfer_tx    = start ? tx_byte : 8'h00;
    rsp_valid  = rsp_valid_q;
    rsp_data   = rsp_data_q;
    rsp_last   = rsp_last_q;
  end
endmodule

// File: tb/tb_spi_flash_cmd_seq.sv
// Bench for spi_flash_cmd_seq: shift-engine model, command-level expectation queues,
// one per-cycle compare process, plus literal checks on logged traffic.
module tb_spi_flash_cmd_seq;
  localparam int S = 2, H = 2, D = 4, T = 16;

  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [23:0] cmd_addr = 24'h0;
  logic [7:0] cmd_len = 8'h0;
  logic rsp_valid, rsp_last, busy, err, cs_n, xfer_start;
  logic [7:0] rsp_data, xfer_tx;
  logic xfer_done = 1'b0;
  logic [7:0] xfer_rx = 8'h00;

  always #5 clk = ~clk;

  spi_flash_cmd_seq #(.CS_SETUP_CYC(S), .CS_HOLD_CYC(H), .CS_DESEL_CYC(D), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy), .err(err), .cs_n(cs_n), .xfer_start(xfer_start),
    .xfer_tx(xfer_tx), .xfer_done(xfer_done), .xfer_rx(xfer_rx));

  int total = 0, bad = 0, cyc = 0;
  logic [7:0] exp_tx[$], eng_rx[$], tx_log[$], rsp_log[$];
  logic [8:0] exp_rsp[$];
  int cs_fall = -1000, cs_rise = -1000, last_done = -1000, acc_cyc = -1, exp_err = -1;
  int n_acc = 0, n_last = 0, n_err = 0, eng_lat = 2;
  bit outst = 0, first_start = 0, prev_cs = 1, tmo_mode = 0, eng_hold = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Command-level model: opcode, address bytes, then the op's data byte count of dummies
  task automatic model_cmd(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] len,
                           input logic [7:0] pat[$]);
    int n;
    logic [7:0] opc;
    opc = (op == 0) ? 8'h9F : (op == 1) ? 8'h05 : (op == 2) ? 8'h03 : 8'h06;
    n   = (op == 0) ? 3 : (op == 1) ? 1 : (op == 2) ? int'(len) + 1 : 0;
    exp_tx.push_back(opc); eng_rx.push_back(8'hEE);
    if (op == 2) for (int i = 2; i >= 0; i--) begin
      exp_tx.push_back(addr[8*i +: 8]); eng_rx.push_back(8'hEE);
    end
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(8'h00); eng_rx.push_back(pat[i]);
      exp_rsp.push_back({i == n - 1, pat[i]});
    end
  endtask

  task automatic chk_log(input string nm, input logic [7:0] got[$], input logic [7:0] want[$]);
    check({nm, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++) check(nm, got[i], want[i]);
  endtask

  task automatic issue(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] len, input bit keep);
    int k;
    bit ok;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len;
    k = n_acc; ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (n_acc != k) begin ok = 1; break; end
    end
    check("accept_bound", ok, 1);
    if (!keep) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = 2'd3; cmd_addr = 24'hFFFFFF; cmd_len = 8'hFF;
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (!busy) begin ok = 1; break; end
    end
    check(nm, ok, 1);
    check("exp_tx_drained", exp_tx.size(), 0);
    check("exp_rsp_drained", exp_rsp.size(), 0);
  endtask

  // Shift engine: answers each xfer_start after eng_lat cycles unless held or reset
  initial begin
    logic [7:0] b;
    bit ab;
    forever begin
      @(negedge clk);
      if (xfer_start && !reset && !eng_hold) begin
        if (eng_rx.size() > 0) b = eng_rx.pop_front(); else b = 8'hFF;
        ab = 0;
        for (int k = 0; k < eng_lat; k++) begin @(posedge clk); if (reset) ab = 1; end
        if (!ab) begin
          #1 xfer_done = 1'b1; xfer_rx = b;
          @(posedge clk); #1 xfer_done = 1'b0; xfer_rx = 8'h00;
        end
      end
    end
  end

  // Per-cycle compare against the model queues and framing rules
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        outst = 0; prev_cs = 1; cs_rise = -1000; last_done = -1000; first_start = 0;
      end else begin
        if (cs_n != prev_cs) begin
          if (!cs_n) begin cs_fall = cyc; first_start = 1; end
          else begin
            if (last_done >= 0) check("cs_hold", cyc - last_done, H + 1);
            cs_rise = cyc;
          end
        end
        prev_cs = cs_n;
        if (xfer_start) begin
          check("start_cs_low", cs_n, 0);
          check("start_while_outstanding", outst, 0);
          if (first_start) begin check("cs_setup", cyc - cs_fall, S); first_start = 0; end
          if (exp_tx.size() == 0) check("unexpected_start", 1, 0);
          else check("xfer_tx", xfer_tx, exp_tx.pop_front());
          tx_log.push_back(xfer_tx);
          outst = 1;
          if (tmo_mode) exp_err = cyc + T;
        end
        if (xfer_done && outst) begin outst = 0; last_done = cyc; end
        if (rsp_valid) begin
          check("rsp_latency", cyc - last_done, 1);
          if (exp_rsp.size() == 0) check("unexpected_rsp", 1, 0);
          else begin
            e = exp_rsp.pop_front();
            check("rsp_data", rsp_data, e[7:0]);
            check("rsp_last", rsp_last, e[8]);
          end
          rsp_log.push_back(rsp_data);
        end
        if (rsp_last) n_last++;
        if (err) n_err++;
        check("err", err, cyc == exp_err);
        if (cyc == exp_err) begin last_done = cyc - 1; outst = 0; end
        check("ready_vs_busy", cmd_ready, !busy);
        if (cmd_ready) check("desel_min", (cyc - cs_rise) >= D, 1);
        if (cmd_valid && cmd_ready) begin acc_cyc = cyc; n_acc++; end
      end
    end
  end

  initial begin
    logic [7:0] pat[$], lit[$];
    int nl;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0); check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);   check("rst_rsp_last", rsp_last, 0);
    check("rst_busy", busy, 0);           check("rst_err", err, 0);
    check("rst_cs_n", cs_n, 1);           check("rst_xfer_start", xfer_start, 0);
    check("rst_xfer_tx", xfer_tx, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_cs_n", cs_n, 1); check("idle_ready", cmd_ready, 1); check("idle_busy", busy, 0);
    check("idle_no_start", tx_log.size(), 0);

    // RDID
    eng_lat = 2; pat = {8'h20, 8'hBA, 8'h18};
    model_cmd(2'd0, 24'h0, 8'h0, pat);
    issue(2'd0, 24'hABCDEF, 8'h07, 0);
    wait_idle("rdid_done");
    lit = {8'h9F, 8'h00, 8'h00, 8'h00}; chk_log("rdid_tx", tx_log, lit);
    lit = {8'h20, 8'hBA, 8'h18};        chk_log("rdid_rsp", rsp_log, lit);
    check("rdid_last_cnt", n_last, 1);

    // READ 4 bytes, fastest engine
    tx_log.delete(); rsp_log.delete(); pat.delete();
    for (int i = 0; i < 256; i++) pat.push_back(8'(i) ^ 8'h5A);
    eng_lat = 1;
    model_cmd(2'd2, 24'h012345, 8'h03, pat);
    issue(2'd2, 24'h012345, 8'h03, 0);
    wait_idle("read4_done");
    lit = {8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00}; chk_log("read4_tx", tx_log, lit);
    lit = {8'h5A, 8'h5B, 8'h58, 8'h59};                             chk_log("read4_rsp", rsp_log, lit);

    // WREN then RDSR with cmd_valid held across both
    tx_log.delete(); rsp_log.delete(); eng_lat = 3; nl = n_last;
    model_cmd(2'd3, 24'h0, 8'h0, pat);
    lit = {8'hA5}; model_cmd(2'd1, 24'h0, 8'h0, lit);
    issue(2'd3, 24'h0, 8'h0, 1);
    issue(2'd1, 24'h0, 8'h0, 0);
    check("b2b_desel_gap", acc_cyc - cs_rise, D);
    wait_idle("b2b_done");
    lit = {8'h06, 8'h05, 8'h00}; chk_log("b2b_tx", tx_log, lit);
    lit = {8'hA5};               chk_log("b2b_rsp", rsp_log, lit);
    check("b2b_last_cnt", n_last - nl, 1);

    // READ 256 bytes
    tx_log.delete(); rsp_log.delete(); eng_lat = 1; nl = n_last;
    model_cmd(2'd2, 24'hFFFFFE, 8'hFF, pat);
    issue(2'd2, 24'hFFFFFE, 8'hFF, 0);
    wait_idle("read256_done");
    check("read256_cnt", rsp_log.size(), 256);
    check("read256_first", rsp_log[0], 8'h5A);
    check("read256_final", rsp_log[255], 8'hA5);
    check("read256_last_cnt", n_last - nl, 1);

    // Reset in the middle of the address phase
    tx_log.delete(); rsp_log.delete(); eng_lat = 3;
    model_cmd(2'd2, 24'hC0FFEE, 8'h01, pat);
    issue(2'd2, 24'hC0FFEE, 8'h01, 0);
    for (int i = 0; i < 200 && tx_log.size() < 2; i++) @(posedge clk);
    check("reached_addr", tx_log.size(), 2);
    #1 reset = 1'b1;
    exp_tx.delete(); exp_rsp.delete(); eng_rx.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_cs_n", cs_n, 1); check("mid_rst_busy", busy, 0);
    nl = n_err;
    repeat (20) @(negedge clk);
    check("mid_rst_no_rsp", rsp_log.size(), 0);
    check("mid_rst_no_err", n_err - nl, 0);

    // Recovery
    tx_log.delete(); eng_lat = 2;
    lit = {8'h3C}; model_cmd(2'd1, 24'h0, 8'h0, lit);
    issue(2'd1, 24'h0, 8'h0, 0);
    wait_idle("recover_done");
    chk_log("recover_rsp", rsp_log, lit);

`ifdef SPI_SEQ_TIMEOUT_EN
    rsp_log.delete(); nl = n_last;
    exp_tx.push_back(8'h05);
    eng_hold = 1; tmo_mode = 1;
    issue(2'd1, 24'h0, 8'h0, 0);
    wait_idle("tmo_done");
    check("tmo_err_cnt", n_err, 1);
    check("tmo_no_rsp", rsp_log.size(), 0);
    check("tmo_no_last", n_last - nl, 0);
    eng_hold = 0; tmo_mode = 0; exp_err = -1;
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_flash_cmd_seq.md
Name: spi_flash_cmd_seq

Overview:
Command sequencer for the SPI flash path. Accepts one flash command at a time from a host and drives chip-select. It sequences a byte-level SPI shift engine through the opcode, address and data phases, and returns read bytes to the host. Supported commands: RDID (JEDEC ID), RDSR (status), READ (data) and WREN.

Parameters:
CS_SETUP_CYC, 2, clk cycles between cs_n falling and the first xfer_start (min 1)
CS_HOLD_CYC, 2, clk cycles between the last xfer_done and cs_n rising (min 1)
CS_DESEL_CYC, 4, minimum clk cycles cs_n stays high before the next command is accepted (min 1)
TIMEOUT_CYC, 1024, clk cycles allowed from xfer_start to xfer_done (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  host command request
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  2  0=RDID(0x9F), 1=RDSR(0x05), 2=READ(0x03), 3=WREN(0x06)
cmd_addr  in  24  READ start address, sent MSB byte first
cmd_len  in  8  READ byte count minus 1 (1..256 bytes); ignored for other ops
rsp_valid  out  1  one-cycle pulse, rsp_data valid
rsp_data  out  8  byte received from flash
rsp_last  out  1  qualifies the final rsp_valid of a command
busy  out  1  high from command accept until return to IDLE
err  out  1  one-cycle pulse on timeout abort (held 0 when feature is compiled out)
cs_n  out  1  flash chip select, active low
xfer_start  out  1  one-cycle pulse requesting one 8-bit SPI exchange
xfer_tx  out  8  byte to shift out, valid while xfer_start is high
xfer_done  in  1  one-cycle pulse, exchange complete
xfer_rx  in  8  byte shifted in, valid while xfer_done is high

Behaviour:
- Reset values: cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_last=0, busy=0, err=0, cs_n=1, xfer_start=0, xfer_tx=0, state=IDLE.
- Reset asserted mid-command: next edge returns the block to IDLE with cs_n=1. No rsp/err is produced. The shift engine is reset by the same reset.
- cmd_ready=1 only in IDLE. A command is accepted on the edge where cmd_valid&&cmd_ready. op, addr and len are latched at that edge. cmd_* are don't-care afterwards.
- States:
  - IDLE: cs_n=1. On accept, go to CS_SETUP and drive cs_n=0 from the next cycle.
  - CS_SETUP: count CS_SETUP_CYC cycles, then go to OPCODE.
  - OPCODE: pulse xfer_start with xfer_tx=opcode, then wait for xfer_done. The opcode's xfer_rx is discarded. Next state: READ→ADDR; RDID/RDSR→DATA; WREN→CS_HOLD.
  - ADDR: three exchanges sending addr[23:16], addr[15:8], addr[7:0]. rx is discarded. Then go to DATA.
  - DATA: exchanges with xfer_tx=0x00. Byte counts: RDID 3, RDSR 1, READ cmd_len+1. Each xfer_done produces rsp_valid=1 and rsp_data=xfer_rx in the following cycle (1-cycle latency). rsp_last is set on the final byte. After the final byte, go to CS_HOLD.
  - CS_HOLD: count CS_HOLD_CYC cycles, then set cs_n=1 and go to DESEL.
  - DESEL: count CS_DESEL_CYC cycles with cs_n=1, then go to IDLE.
- Exchange handshake: xfer_start is never asserted while an exchange is outstanding. The next xfer_start comes no earlier than the cycle after xfer_done. xfer_done arriving outside an outstanding exchange is ignored.
- Counters: the data byte counter is 9 bits, so cmd_len=0xFF yields exactly 256 bytes.
- Address: taken verbatim; no wrap handling. Wrap behaviour is the flash's.
- rsp interface has no backpressure. The host must sink each pulse.
- busy=1 in every state except IDLE.

Optional Feature:
SPI_SEQ_TIMEOUT_EN.
- Defined: a counter starts at each xfer_start. If xfer_done has not arrived TIMEOUT_CYC cycles after xfer_start, the block pulses err for 1 cycle and jumps to CS_HOLD. That forces cs_n high after the hold, and no rsp_last is produced. A late xfer_done is ignored.
- Undefined: no counter; the block waits for xfer_done indefinitely; err is tied to 0.

Test Plan:
- Reset, then idle 10 cycles → cs_n=1, cmd_ready=1, busy=0, no xfer_start.
- RDID; engine model returns 0x20,0xBA,0x18 → xfer_tx sequence 0x9F,0x00,0x00,0x00; three rsp pulses 0x20,0xBA,0x18 with rsp_last on 0x18; cs_n low ≥CS_SETUP_CYC before the first start.
- READ addr=0x012345, len=0x03 → tx 0x03,0x01,0x23,0x45 then 4 dummies; exactly 4 rsp pulses; then cs_n high for ≥CS_DESEL_CYC before cmd_ready=1.
- WREN back-to-back with RDSR (cmd_valid held high) → single 0x06 exchange, no rsp; RDSR is accepted only after DESEL; RDSR returns 1 byte with rsp_last=1.
- READ len=0xFF → exactly 256 rsp pulses, rsp_last on the 256th only.
- Reset asserted during ADDR phase → cs_n=1 on the next cycle, no rsp/err; with SPI_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, withholding xfer_done → err pulse at cycle 16, cs_n high after CS_HOLD_CYC.
